// File: rtl/vip_pkg.sv
// Shared constants for the video downscale blocks: factor encoding width,
// accumulator growth for up to 8x8 boxes, and the pixel pipeline depth.
package vip_pkg;

  localparam int FACTOR_W = 2;   // log2 factor 0..3 -> 1,2,4,8
  localparam int ACC_GROW = 3;   // horizontal sum of up to 8 samples
  localparam int LB_GROW  = 6;   // box sum of up to 64 samples
  localparam int PIPE_LAT = 2;   // input sample to output pixel, in pclk cycles

  typedef logic [FACTOR_W-1:0] factor_t;

  function automatic int acc_bits(input int bits);
    return bits + ACC_GROW;
  endfunction

  function automatic int lb_bits(input int bits);
    return bits + LB_GROW;
  endfunction

endpackage

// File: rtl/vip_dscale_avg_if.sv
// DVP-style pixel stream bundle: vsync marks frames, href qualifies data.
// Handshake: valid-only -- href high means data holds a pixel this cycle; there is no ready, the sink must take every pixel.
interface vip_dscale_avg_if #(
  parameter int DW = 8
);
  logic          href;
  logic          vsync;
  logic [DW-1:0] data;

  modport master (output href, output vsync, output data);
  modport slave  (input  href, input  vsync, input  data);
endinterface

// File: rtl/vip_dscale_linebuf.sv
// Simple dual-port line buffer: one write port, one registered read port.
// Contents are not reset; the first line of each vertical group overwrites them.
module vip_dscale_linebuf #(
  parameter int DEPTH = 1280,
  parameter int DW    = 14,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vip_dscale_avg.sv
// Box-average downscaler for a DVP pixel stream (2^h x 2^v blocks, per channel).
// Optional macro VIP_DSCALE_ROUND_EN: round half up before the final shift instead of truncating.
module vip_dscale_avg
  import vip_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int CHANNELS = 1,
  parameter int WIDTH    = 1280,
  parameter int HEIGHT   = 720
) (
  input  logic                     pclk,
  input  logic                     rst_n,
  input  logic [FACTOR_W-1:0]      dscale_h,
  input  logic [FACTOR_W-1:0]      dscale_v,
  input  logic                     in_href,
  input  logic                     in_vsync,
  input  logic [BITS*CHANNELS-1:0] in_data,
  output logic                     out_pclk,
  output logic                     out_href,
  output logic                     out_vsync,
  output logic [BITS*CHANNELS-1:0] out_data
);

  localparam int DW  = BITS * CHANNELS;
  localparam int ACW = acc_bits(BITS);
  localparam int LW  = lb_bits(BITS);
  localparam int CW  = ($clog2(WIDTH + 1) < 4) ? 4 : $clog2(WIDTH + 1);
  localparam int LNW = ($clog2(HEIGHT + 1) < 1) ? 1 : $clog2(HEIGHT + 1);
  localparam int XW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  assign out_pclk = pclk;

  // frame state
  logic           href_d;
  logic           vsync_d;
  factor_t        fh;
  factor_t        fv;
  logic           armed;
  logic [CW-1:0]  col;
  logic [2:0]     v_phase;
  logic [LNW-1:0] line_cnt;
  logic [PIPE_LAT-1:0] vs_pipe;

  // stage 0: horizontal accumulation
  logic [ACW-1:0] acc     [CHANNELS];
  logic [ACW-1:0] acc_nxt [CHANNELS];
  logic           vs_rise;
  logic           href_fall;
  logic [2:0]     h_mask;
  logic [2:0]     v_mask;
  logic [2:0]     h_phase;
  logic           h_start;
  logic           pix_ok;
  logic           blk_end;
  logic           first_line;
  logic           last_line;
  logic [XW-1:0]  raddr;

  // stage 1: vertical accumulation / output
  logic           s1_valid;
  logic           s1_first;
  logic           s1_last;
  logic [XW-1:0]  s1_addr;
  logic [2:0]     s1_sh;
  logic [ACW-1:0] s1_hsum [CHANNELS];
  logic [LW-1:0]  total   [CHANNELS];
  logic [LW-1:0]  rnd;
  logic [DW-1:0]  avg_px;
  logic [LW*CHANNELS-1:0] lb_wdata;
  logic [LW*CHANNELS-1:0] lb_rdata;
  logic           lb_we;

  assign vs_rise    = in_vsync & ~vsync_d;
  assign href_fall  = href_d & ~in_href;
  assign h_mask     = ~(3'b111 << fh);
  assign v_mask     = ~(3'b111 << fv);
  assign h_phase    = col[2:0] & h_mask;
  assign h_start    = (h_phase == 3'd0);
  assign first_line = (v_phase == 3'd0);
  assign last_line  = (v_phase == v_mask);
  // Pixels past WIDTH, lines past HEIGHT and anything before the first vsync are dropped here.
  assign pix_ok     = armed & in_href & ~vs_rise & (col < CW'(WIDTH)) & (line_cnt < LNW'(HEIGHT));
  assign blk_end    = pix_ok & (h_phase == h_mask);
  assign raddr      = pix_ok ? XW'(col >> fh) : '0;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      acc_nxt[c] = (h_start ? '0 : acc[c]) + ACW'(in_data[c*BITS +: BITS]);
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      href_d   <= 1'b0;
      vsync_d  <= 1'b0;
      fh       <= '0;
      fv       <= '0;
      armed    <= 1'b0;
      col      <= '0;
      v_phase  <= '0;
      line_cnt <= '0;
      vs_pipe  <= '0;
      for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
    end else begin
      href_d  <= in_href;
      vsync_d <= in_vsync;
      vs_pipe <= {vs_pipe[PIPE_LAT-2:0], in_vsync};
      if (vs_rise) begin
        fh       <= dscale_h;
        fv       <= dscale_v;
        armed    <= 1'b1;
        col      <= '0;
        v_phase  <= '0;
        line_cnt <= '0;
      end else begin
        if (!in_href)                col <= '0;
        else if (col < CW'(WIDTH))   col <= col + 1'b1;
        if (href_fall && (line_cnt < LNW'(HEIGHT))) begin
          line_cnt <= line_cnt + 1'b1;
          v_phase  <= last_line ? 3'd0 : v_phase + 3'd1;
        end
      end
      if (pix_ok) begin
        for (int c = 0; c < CHANNELS; c++) acc[c] <= acc_nxt[c];
      end
    end
  end

  assign out_vsync = vs_pipe[PIPE_LAT-1];

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_addr  <= '0;
      s1_sh    <= '0;
      for (int c = 0; c < CHANNELS; c++) s1_hsum[c] <= '0;
    end else begin
      s1_valid <= blk_end;
      s1_first <= first_line;
      s1_last  <= last_line;
      s1_addr  <= raddr;
      s1_sh    <= {1'b0, fh} + {1'b0, fv};
      for (int c = 0; c < CHANNELS; c++) s1_hsum[c] <= acc_nxt[c];
    end
  end

`ifdef VIP_DSCALE_ROUND_EN
  assign rnd = (s1_sh == 3'd0) ? '0 : (LW'(1) << (s1_sh - 3'd1));
`else
  assign rnd = '0;
`endif

  // The first line of a group seeds the column sum; later lines add onto the stored value.
  always_comb begin
    avg_px   = '0;
    lb_wdata = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      total[c] = (s1_first ? '0 : lb_rdata[c*LW +: LW]) + LW'(s1_hsum[c]);
      lb_wdata[c*LW +: LW]  = total[c];
      avg_px[c*BITS +: BITS] = BITS'((total[c] + rnd) >> s1_sh);
    end
  end

  assign lb_we = s1_valid & ~s1_last;

  vip_dscale_linebuf #(
    .DEPTH (WIDTH),
    .DW    (LW * CHANNELS)
  ) u_linebuf (
    .clk   (pclk),
    .we    (lb_we),
    .waddr (s1_addr),
    .wdata (lb_wdata),
    .raddr (raddr),
    .rdata (lb_rdata)
  );

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      out_href <= 1'b0;
      out_data <= '0;
    end else begin
      out_href <= s1_valid & s1_last;
      if (s1_valid && s1_last) out_data <= avg_px;
    end
  end

endmodule

// File: tb/tb_vip_dscale_avg.sv
// Directed bench for vip_dscale_avg on a reduced 18x11 frame with 3 channels.
// Expected pixels come from a box-average model over the stored stimulus image.
module tb_vip_dscale_avg;
  import vip_pkg::*;

  localparam int BITS   = 8;
  localparam int CH     = 3;
  localparam int WIDTH  = 18;
  localparam int HEIGHT = 11;
  localparam int DW     = BITS * CH;

  // clock / reset
  logic pclk  = 1'b0;
  logic rst_n = 1'b0;
  logic [FACTOR_W-1:0] dscale_h = '0;
  logic [FACTOR_W-1:0] dscale_v = '0;
  logic out_pclk;
  int unsigned cyc = 0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  vip_dscale_avg_if #(.DW(DW)) vin ();
  vip_dscale_avg_if #(.DW(DW)) vout ();

  vip_dscale_avg #(
    .BITS(BITS), .CHANNELS(CH), .WIDTH(WIDTH), .HEIGHT(HEIGHT)
  ) dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .dscale_h  (dscale_h),
    .dscale_v  (dscale_v),
    .in_href   (vin.href),
    .in_vsync  (vin.vsync),
    .in_data   (vin.data),
    .out_pclk  (out_pclk),
    .out_href  (vout.href),
    .out_vsync (vout.vsync),
    .out_data  (vout.data)
  );

  // scoreboard
  logic [DW-1:0] exp_q[$];
  int unsigned   cyc_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  logic [DW-1:0] last_out = '0;
  logic armed_m = 1'b0;
  int img [0:15][0:23][0:2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // monitor
  initial begin : monitor
    logic vs_d1, vs_d2;
    logic [DW-1:0] e;
    int unsigned c;
    vs_d1 = 1'b0;
    vs_d2 = 1'b0;
    forever begin
      @(negedge pclk);
      if (!rst_n) begin
        vs_d1 = 1'b0;
        vs_d2 = 1'b0;
      end else begin
        check("vsync_dly", 32'(vout.vsync), 32'(vs_d2));
        vs_d2 = vs_d1;
        vs_d1 = vin.vsync;
        if (vout.href === 1'b1) begin
          pulses++;
          last_out = vout.data;
          if (exp_q.size() == 0) begin
            check("spurious_href", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            check("pix_data", 32'(vout.data), 32'(e));
            check("pix_cycle", cyc, c);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  function automatic int pixval(input int kind, input int x, input int y, input int c);
    case (kind)
      0:       return (x * 7 + y * 13 + c * 50) & 255;
      1:       return 100;
      2:       return ((x % 2 == 0) && (y % 2 == 0)) ? 1 : 2;
      3:       return 255;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  function automatic logic [DW-1:0] box_avg(input int x1, input int y1, input int fh, input int fv);
    logic [DW-1:0] r;
    int s;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      s = 0;
      for (int yy = y1 - (1 << fv) + 1; yy <= y1; yy++)
        for (int xx = x1 - (1 << fh) + 1; xx <= x1; xx++)
          s += img[yy][xx][c];
`ifdef VIP_DSCALE_ROUND_EN
      if (fh + fv > 0) s += 1 << (fh + fv - 1);
`endif
      r[c*BITS +: BITS] = 8'(s >> (fh + fv));
    end
    return r;
  endfunction

  task automatic drive_frame(input string name, input int fh, input int fv, input int npx,
                             input int nlines, input int kind, input int mid_line,
                             input int mid_h, input int rst_line, input int exp_pulses);
    int hh, vv;
    dscale_h = 2'(fh);
    dscale_v = 2'(fv);
    vin.href = 1'b0;
    vin.vsync = 1'b1;
    repeat (3) tick();
    vin.vsync = 1'b0;
    repeat (3) tick();
    armed_m = 1'b1;
    pulses = 0;
    hh = 1 << fh;
    vv = 1 << fv;
    for (int y = 0; y < nlines; y++) begin
      if (y == mid_line) dscale_h = 2'(mid_h);
      for (int x = 0; x < npx; x++) begin
        if (y == rst_line && x == 5) begin
          rst_n = 1'b0;
          #1;
          check({name, "_rst_href"}, 32'(vout.href), 32'd0);
          check({name, "_rst_data"}, 32'(vout.data), 32'd0);
          exp_q.delete();
          cyc_q.delete();
          armed_m = 1'b0;
          #2;
          rst_n = 1'b1;
        end
        for (int c = 0; c < CH; c++) begin
          img[y][x][c] = pixval(kind, x, y, c);
          vin.data[c*BITS +: BITS] = 8'(img[y][x][c]);
        end
        vin.href = 1'b1;
        if (armed_m && x < WIDTH && y < HEIGHT && (x % hh) == hh - 1 && (y % vv) == vv - 1) begin
          exp_q.push_back(box_avg(x, y, fh, fv));
          cyc_q.push_back(cyc + 2);
        end
        tick();
      end
      vin.href = 1'b0;
      repeat (4) tick();
    end
    repeat (6) tick();
    check({name, "_pulses"}, pulses, exp_pulses);
    check({name, "_left"}, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin : main
    vin.href  = 1'b0;
    vin.vsync = 1'b0;
    vin.data  = '0;
    repeat (3) tick();
    check("reset_href", 32'(vout.href), 32'd0);
    check("reset_vsync", 32'(vout.vsync), 32'd0);
    check("reset_data", 32'(vout.data), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // a line before any vsync must produce nothing
    pulses = 0;
    for (int x = 0; x < WIDTH; x++) begin
      vin.data = DW'(x * 3);
      vin.href = 1'b1;
      tick();
    end
    vin.href = 1'b0;
    repeat (6) tick();
    check("pre_vsync_pulses", pulses, 0);

    // pass-through, over-long lines
    drive_frame("pass", 0, 0, 20, 11, 0, -1, 0, -1, 198);
    // constant 100 at 2x2; 12th line is beyond HEIGHT
    drive_frame("const", 1, 1, 18, 12, 1, -1, 0, -1, 45);
    check("const_value", 32'(last_out), 32'h646464);
    // 1,2,2,2 blocks
    drive_frame("block", 1, 1, 18, 2, 2, -1, 0, -1, 9);
`ifdef VIP_DSCALE_ROUND_EN
    check("block_value", 32'(last_out), 32'h020202);
`else
    check("block_value", 32'(last_out), 32'h010101);
`endif
    // all-255 at 8x8, no overflow
    drive_frame("sat", 3, 3, 18, 11, 3, -1, 0, -1, 2);
    check("sat_value", 32'(last_out), 32'hFFFFFF);
    // 4x4 with partial blocks and partial groups
    drive_frame("rand4", 2, 2, 19, 11, 4, -1, 0, -1, 8);
    // factor change mid-frame applies only from the next frame
    drive_frame("midchg", 1, 0, 18, 4, 0, 2, 2, -1, 36);
    drive_frame("nextfr", 2, 0, 18, 4, 4, -1, 0, -1, 16);
    // reset mid-line, then a clean frame
    drive_frame("rstmid", 1, 1, 18, 11, 0, -1, 0, 4, 18);
    drive_frame("after", 1, 1, 18, 11, 4, -1, 0, -1, 45);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vip_dscale_avg.md
VIP_DSCALE_AVG -- requirements
Module: vip_dscale_avg

Interface
REQ-001 SHALL have parameter BITS, default 8: bits per channel sample.
REQ-002 SHALL have parameter CHANNELS, default 1: samples packed per pixel, channel 0 in LSBs.
REQ-003 SHALL have parameter WIDTH, default 1280: input active pixels per line.
REQ-004 SHALL have parameter HEIGHT, default 720: input active lines per frame.
REQ-005 SHALL have port pclk, input, 1: the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port dscale_h, input, 2: horizontal log2 factor (0..3 -> 1,2,4,8).
REQ-008 SHALL have port dscale_v, input, 2: vertical log2 factor (0..3 -> 1,2,4,8).
REQ-009 SHALL have ports in_href, in_vsync, input, 1 each: DVP line valid and frame sync, active high.
REQ-010 SHALL have port in_data, input, BITS*CHANNELS: input pixel.
REQ-011 SHALL have port out_pclk, output, 1: copy of pclk.
REQ-012 SHALL have ports out_href, out_vsync, output, 1 each: output pixel valid and frame sync.
REQ-013 SHALL have port out_data, output, BITS*CHANNELS: box-averaged output pixel.

Function
REQ-014 SHALL sample dscale_h/dscale_v into frame registers on in_vsync rising edge only; mid-frame changes have no effect.
REQ-015 SHALL average each channel independently over a (2^dscale_h) x (2^dscale_v) non-overlapping block.
REQ-016 SHALL accumulate horizontally per channel in a BITS+3 bit accumulator, cleared at each block start and at in_href rising edge.
REQ-017 SHALL store horizontal sums per output column in a line buffer of BITS+6 bits per channel, depth WIDTH; first line of a vertical group writes, subsequent lines read-modify-write.
REQ-018 SHALL compute output = total sum >> (dscale_h+dscale_v) per channel.
REQ-019 SHALL, on the last line of a vertical group, assert out_href exactly one cycle per completed block, 2 pclk cycles after the block's last input pixel.
REQ-020 SHALL hold out_href low on all other cycles; out_data is don't-care when out_href is low.
REQ-021 SHALL drive out_vsync as in_vsync delayed by 2 pclk cycles.
REQ-022 SHALL discard trailing partial horizontal blocks (line length not a multiple of 2^dscale_h).
REQ-023 SHALL discard trailing lines not forming a complete vertical group before the next in_vsync rising edge.
REQ-024 SHALL count lines on in_href falling edges; lines longer than WIDTH SHALL have excess pixels ignored.
REQ-025 SHALL, on in_vsync rising edge mid-frame, reset column, line and group counters; line buffer contents are then overwritten by the next group's first line.
REQ-026 SHALL with dscale_h=dscale_v=0 pass in_data to out_data unchanged, out_href = in_href delayed 2 cycles.

Reset
REQ-027 SHALL on rst_n low asynchronously clear out_href, out_vsync, out_data, all counters, accumulators and frame registers (factor 1x1).
REQ-028 SHALL not require line buffer contents to be reset.
REQ-029 SHALL suppress output until the first in_vsync rising edge after reset release.

Configuration
REQ-030 SHALL support macro VIP_DSCALE_ROUND_EN: defined -> add 2^(dscale_h+dscale_v-1) before shift (round half up, zero when shift is 0); undefined -> truncate.

Structure
REQ-031 SHALL place the factor encoding width, accumulator width constants (BITS+3, BITS+6) and pipeline latency (2) in shared package vip_pkg.
REQ-032 SHALL instantiate one sub-module vip_dscale_linebuf: simple dual-port RAM, one write and one registered read port, depth WIDTH, width (BITS+6)*CHANNELS.

Verification
REQ-033 SHALL verify 1280x720 gray ramp, dscale_h=dscale_v=0 -> output bit-identical to input, 921600 out_href pulses.
REQ-034 SHALL verify constant 8'd100, dscale_h=dscale_v=1 -> 640x360 pixels, all 100, 230400 pulses per frame.
REQ-035 SHALL verify 2x2 block values 1,2,2,2 with factor 2x2 -> output 1 without VIP_DSCALE_ROUND_EN, 2 with it.
REQ-036 SHALL verify CHANNELS=3, all-255 input, factor 8x8 -> 160x90 pixels each 24'hFFFFFF (no overflow).
REQ-037 SHALL verify WIDTH=1283, HEIGHT=723, factor 4x4 -> exactly 320 pixels per line, 180 output lines.
REQ-038 SHALL verify dscale_h changed from 1 to 2 mid-frame -> current frame 640 wide, next frame 320 wide; rst_n pulse mid-line -> out_href low immediately, no output until next vsync.
